jtag_scan_master: RTL
=====================

# jtag_scan_master

Clocked JTAG master that drives a 4-bit-state TAP (TCK/TMS/TDI/TDO) from a simple command/response interface on the system clock. It generates TCK by division, tracks the TAP state internally, and sequences complete IR or DR scans. Each scan runs from Run-Test/Idle back to Run-Test/Idle and returns the captured TDO bits. It sits between on-chip debug/test logic and the TAP pins, so a single requester can run scans without bit-banging.

## Interface
Parameters:
- MAX_LEN, 32, maximum scan length in bits; CMD_DATA/RSP_DATA width.
- DIV, 2, CLK cycles per TCK half-period (≥1).

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  master idle in Run-Test/Idle; command accepted when VALID&READY.
- CMD_IR  in  1  1 = IR scan, 0 = DR scan.
- CMD_LEN  in  6  scan length in bits; legal 1..MAX_LEN.
- CMD_DATA  in  MAX_LEN  TDI bits, bit 0 shifted first.
- RSP_VALID  out  1  one-cycle pulse: scan complete.
- RSP_DATA  out  MAX_LEN  captured TDO, bit i = i-th bit shifted; bits ≥ LEN are zero.
- RSP_ERR  out  1  qualifies RSP_VALID: illegal CMD_LEN.
- TCK_O  out  1  TAP clock.
- TMS_O  out  1  TAP mode select.
- TDI_O  out  1  TAP data in.
- TDO_I  in  1  TAP data out.

## Operation
- Reset values: TCK_O=0, TMS_O=1, TDI_O=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0. Internal TAP state is Test-Logic-Reset.
- States: INIT → IDLE → PRE → SHIFT → POST → IDLE; ERR → IDLE.
- INIT: 5 TCKs with TMS=1, then 1 TCK with TMS=0, which puts the TAP in Run-Test/Idle. Then IDLE with CMD_READY=1.
- IDLE: TCK_O held 0, TMS_O=0. Accepting a legal command latches CMD_IR/LEN/DATA and drops CMD_READY in the next cycle.
- PRE: the TMS preamble is 1,0,0 for DR (Select-DR, Capture-DR, Shift-DR) or 1,1,0,0 for IR.
- SHIFT: LEN TCKs. TDI_O = data bit i. TMS=0, except TMS=1 on the last bit (to Exit1).
- POST: TMS 1 (Update), then 0 (Run-Test/Idle).
- Total TCKs: DR = LEN+5; IR = LEN+6.
- TDO is sampled into RSP_DATA[i] at the TCK rising edge of shift bit i only. Non-shift TCKs are never sampled.
- CMD_LEN of 0 or greater than MAX_LEN: command is accepted, no TCK is issued, RSP_VALID=1 and RSP_ERR=1 the next cycle, RSP_DATA=0.
- RSP_DATA holds its value until the next response.
- CMD_VALID while busy is ignored (READY=0); no queuing.

## Timing
- One TCK period = 2·DIV CLK cycles: a low phase of DIV cycles, then a high phase of DIV cycles.
- TMS_O/TDI_O change only on the first CLK of a low phase. The rising edge is at least DIV CLKs after the change.
- TDO_I is registered on the CLK edge where TCK_O goes 0→1.
- Command accept to first TCK rising edge: 1 + DIV CLK cycles.
- RSP_VALID pulses on the CLK after the final high phase ends (TCK_O back to 0). CMD_READY=1 in that same cycle, so back-to-back commands are allowed.
- A legal scan lasts (LEN+5 or LEN+6)·2·DIV + 2 CLKs, accept to RSP_VALID.
- RST at any point, including mid-scan: outputs go to reset values immediately. The in-flight command is dropped with no RSP_VALID, and INIT reruns after RST deasserts.

## Configuration
- JTAG_SCAN_MASTER_TLR_EN defined: adds input CMD_TLR (1 bit).
  - An accepted command with CMD_TLR=1 ignores IR/LEN/DATA.
  - It emits 5 TCKs with TMS=1 and 1 with TMS=0, then pulses RSP_VALID with RSP_DATA=0 and RSP_ERR=0 (6 TCKs total).
- Undefined: CMD_TLR is absent. The TAP is reset only by the INIT sequence after RST.

## Test plan
- Reset release, DIV=2: exactly 6 TCK rising edges with TMS 1,1,1,1,1,0. Then CMD_READY=1 and the bench TAP model reports Run-Test/Idle.
- DR scan, LEN=8, DATA=8'hA5, TAP in BYPASS (capture 0): 13 TCKs, RSP_DATA=8'h4A, RSP_ERR=0, TAP back in Run-Test/Idle.
- IR scan, LEN=4, DATA=4'h1, TAP IR captures 4'b0000: 10 TCKs, RSP_DATA=0, TAP latched IR=4'h1. A following DR scan of LEN=32 on IDCODE returns 32'hFFFFFFFF.
- CMD_LEN=0 and then CMD_LEN=33: no TCK toggles; RSP_VALID with RSP_ERR=1 one cycle after each accept; RSP_DATA=0.
- RST asserted at shift bit 3 of a 32-bit DR scan: TCK_O=0 and TMS_O=1 in the same cycle, no RSP_VALID. INIT reruns and a subsequent 8'hA5 bypass scan returns 8'h4A.
- With JTAG_SCAN_MASTER_TLR_EN: a CMD_TLR command gives 6 TCKs, the TAP is in Run-Test/Idle after Test-Logic-Reset, and RSP_VALID with RSP_DATA=0.

Source files
------------

// File: rtl/jtag_scan_master.sv
// jtag_scan_master
// ----------------
// Clocked JTAG master. It divides the system clock to produce TCK, walks the
// TAP through complete IR or DR scans that start and end in Run-Test/Idle,
// and returns the TDO bits captured during the shift phase.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while idle in RTI)
//   cmd_ir              1 = IR scan, 0 = DR scan
//   cmd_len             scan length in bits (legal 1..MAX_LEN)
//   cmd_data            TDI bits, bit 0 shifted first
//   cmd_tlr             (only with JTAG_SCAN_MASTER_TLR_EN) run a TAP reset
//   rsp_valid           one-cycle pulse when the command completes
//   rsp_data            captured TDO, bit i = i-th shifted bit, upper bits 0
//   rsp_err             qualifies rsp_valid: command had an illegal length
//   tck_o/tms_o/tdi_o   TAP outputs
//   tdo_i               TAP data out
//
// Build option: define JTAG_SCAN_MASTER_TLR_EN to add the cmd_tlr input.
//
// Timing model: every TCK is a low phase of DIV clocks followed by a high
// phase of DIV clocks. TMS/TDI change only on the clock that starts a low
// phase, and TDO is registered on the clock that raises TCK.

module jtag_scan_master #(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_MASTER_TLR_EN
  input  logic               cmd_tlr,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int              DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(DIV - 1);
  localparam logic [6:0]      MAX_LEN_W = 7'(MAX_LEN);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]         state;
  logic [5:0]         idx;
  logic [DW-1:0]      div_cnt;
  logic               lead;
  logic               tlr_run;
  logic               ir;
  logic [5:0]         len;
  logic [MAX_LEN-1:0] sh;
  logic [MAX_LEN-1:0] cap;

  logic               tlr_req;
  logic               len_ok;
  logic [6:0]         shamt;
  logic [5:0]         pre_last;

`ifdef JTAG_SCAN_MASTER_TLR_EN
  assign tlr_req = cmd_tlr;
`else
  assign tlr_req = 1'b0;
`endif

  assign len_ok   = (cmd_len != 6'd0) && ({1'b0, cmd_len} <= MAX_LEN_W);
  // Captured bits enter at the top of cap; this realigns them so bit 0 is
  // the first bit shifted and everything above len is zero.
  assign shamt    = MAX_LEN_W - {1'b0, len};
  assign pre_last = ir ? 6'd3 : 6'd2;

  // Reset itself counts as the start of the first INIT low phase, so the
  // 5x TMS=1 / 1x TMS=0 sequence begins right after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      idx       <= '0;
      div_cnt   <= '0;
      lead      <= 1'b0;
      tlr_run   <= 1'b0;
      ir        <= 1'b0;
      len       <= '0;
      sh        <= '0;
      cap       <= '0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tck_o <= 1'b0;
          tms_o <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cap       <= '0;
            idx       <= '0;
            div_cnt   <= '0;
            // One dead clock after accept so the first low phase starts
            // on its own clock, giving 1+DIV clocks to the first rise.
            lead      <= 1'b1;
            if (tlr_req) begin
              state   <= S_INIT;
              tlr_run <= 1'b1;
            end else if (len_ok) begin
              state <= S_PRE;
              ir    <= cmd_ir;
              len   <= cmd_len;
              sh    <= cmd_data;
            end else begin
              state <= S_ERR;
            end
          end
        end

        S_ERR: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
          cmd_ready <= 1'b1;
        end

        S_FIN: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= cap >> shamt;
          tlr_run   <= 1'b0;
          cmd_ready <= 1'b1;
        end

        S_INIT, S_PRE, S_SHIFT, S_POST: begin
          if (lead) begin
            // Both INIT and PRE begin with TMS=1.
            lead    <= 1'b0;
            tms_o   <= 1'b1;
            div_cnt <= '0;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
          end else if (!tck_o) begin
            div_cnt <= '0;
            tck_o   <= 1'b1;
            if (state == S_SHIFT) begin
              cap <= {tdo_i, cap[MAX_LEN-1:1]};
            end
          end else begin
            // End of a high phase: this clock starts the next low phase,
            // so it is where TMS/TDI for the next TCK are launched.
            div_cnt <= '0;
            tck_o   <= 1'b0;
            case (state)
              S_INIT: begin
                if (idx == 6'd5) begin
                  idx <= '0;
                  if (tlr_run) begin
                    state <= S_FIN;
                  end else begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                  end
                end else begin
                  idx   <= idx + 6'd1;
                  tms_o <= (idx < 6'd4);
                end
              end
              S_PRE: begin
                if (idx == pre_last) begin
                  state <= S_SHIFT;
                  idx   <= '0;
                  tms_o <= (len == 6'd1);
                  tdi_o <= sh[0];
                  sh    <= sh >> 1;
                end else begin
                  idx   <= idx + 6'd1;
                  tms_o <= ir && (idx == 6'd0);
                end
              end
              S_SHIFT: begin
                if (idx == len - 6'd1) begin
                  state <= S_POST;
                  idx   <= '0;
                  tms_o <= 1'b1;
                  tdi_o <= 1'b0;
                end else begin
                  idx   <= idx + 6'd1;
                  tdi_o <= sh[0];
                  sh    <= sh >> 1;
                  tms_o <= (idx + 6'd2 == len);
                end
              end
              default: begin
                if (idx == 6'd0) begin
                  idx   <= 6'd1;
                  tms_o <= 1'b0;
                end else begin
                  idx   <= '0;
                  state <= S_FIN;
                end
              end
            endcase
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
